// File: rtl/rom_fetch_sequencer.sv
// Instruction-fetch sequencer for the 10-bit core: walks the program ROM, folds
// unconditional jumps, honours branch redirects and stops on the halt word.
module rom_fetch_sequencer (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [9:0]  rom_addr,
    input  logic [9:0]  rom_data,
    output logic [9:0]  instr,
    output logic [9:0]  instr_pc,
    output logic        instr_valid,
    input  logic        instr_ready,
    input  logic        redirect,
    input  logic [9:0]  redirect_pc,
    output logic        halted,
    output logic [15:0] instr_count
);

    localparam int unsigned AW = 10;
    localparam int unsigned DW = 10;
    localparam int unsigned CW = 16;

    localparam logic [AW-1:0] RESET_PC  = 10'd0;
    localparam logic [DW-1:0] HALT_WORD = 10'b0010000010;
    localparam logic [3:0]    JUMP_OP   = 4'b1000;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t        state;
    logic [AW-1:0] pc;

    logic xfer_c;
    logic load_c;
    logic is_halt_c;
    logic is_jump_c;

    assign rom_addr  = pc;
    assign xfer_c    = instr_valid && instr_ready;
    assign load_c    = (state == RUN) && !redirect && (!instr_valid || instr_ready);
    assign is_halt_c = (rom_data == HALT_WORD);
    assign is_jump_c = (rom_data[9:6] == JUMP_OP);

    // Single sequential process: state, pc, output buffer and transfer counter.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            pc          <= RESET_PC;
            instr       <= '0;
            instr_pc    <= '0;
            instr_valid <= 1'b0;
            halted      <= 1'b0;
            instr_count <= '0;
        end else begin
            // Every handshake counts, including one coinciding with a flush.
            if (xfer_c && (instr_count != {CW{1'b1}})) begin
                instr_count <= instr_count + CW'(1);
            end

            case (state)
                IDLE, HALT: begin
                    if (start) begin
                        state       <= RUN;
                        pc          <= RESET_PC;
                        instr_valid <= 1'b0;
                        halted      <= 1'b0;
                        instr_count <= '0;
                    end
                end

                RUN: begin
                    if (redirect) begin
                        pc          <= redirect_pc;
                        instr_valid <= 1'b0;
                    end else if (load_c) begin
                        if (is_halt_c) begin
                            state       <= HALT;
                            halted      <= 1'b1;
                            instr_valid <= 1'b0;
                        end else if (is_jump_c) begin
                            pc          <= {4'b0000, rom_data[5:0]};
                            instr_valid <= 1'b0;
                        end else begin
                            instr       <= rom_data;
                            instr_pc    <= pc;
                            instr_valid <= 1'b1;
                            pc          <= pc + AW'(1);
                        end
                    end
                end

                default: begin
                    state       <= IDLE;
                    instr_valid <= 1'b0;
                    halted      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_fetch_sequencer.sv
// Directed, table-driven bench for rom_fetch_sequencer with a behavioural ROM.
module tb_rom_fetch_sequencer;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [9:0]  rom_addr;
    logic [9:0]  rom_data;
    logic [9:0]  instr;
    logic [9:0]  instr_pc;
    logic        instr_valid;
    logic        instr_ready;
    logic        redirect;
    logic [9:0]  redirect_pc;
    logic        halted;
    logic [15:0] instr_count;

    logic [9:0] rom [1024];

    int n_chk;
    int n_fail;

    typedef struct {
        logic        start;
        logic        ready;
        logic        redirect;
        logic [9:0]  rpc;
        logic        e_valid;
        logic [9:0]  e_instr;
        logic [9:0]  e_ipc;
        logic [15:0] e_count;
        logic        e_halted;
        logic [9:0]  e_addr;
    } vec_t;

    vec_t tbl[$];

    rom_fetch_sequencer dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .start       (start),
        .rom_addr    (rom_addr),
        .rom_data    (rom_data),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .halted      (halted),
        .instr_count (instr_count)
    );

    assign rom_data = rom[rom_addr];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Default program word: opcode 0100, never a jump or the halt word.
    function automatic logic [9:0] w(input int a);
        return {4'b0100, 6'(a)};
    endfunction

    function automatic vec_t mk(input logic s, input logic rdy, input logic rd,
                                input logic [9:0] rpc, input logic v,
                                input logic [9:0] ins, input logic [9:0] ipc,
                                input logic [15:0] cnt, input logic h,
                                input logic [9:0] addr);
        vec_t r;
        r.start = s;     r.ready = rdy;  r.redirect = rd; r.rpc = rpc;
        r.e_valid = v;   r.e_instr = ins; r.e_ipc = ipc;  r.e_count = cnt;
        r.e_halted = h;  r.e_addr = addr;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, " rom_addr"},    32'(rom_addr),    32'd0);
        chk({tag, " instr"},       32'(instr),       32'd0);
        chk({tag, " instr_pc"},    32'(instr_pc),    32'd0);
        chk({tag, " instr_valid"}, 32'(instr_valid), 32'd0);
        chk({tag, " halted"},      32'(halted),      32'd0);
        chk({tag, " instr_count"}, 32'(instr_count), 32'd0);
    endtask

    initial begin
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 1024; i++) rom[i] = w(i);
        rom[7]  = 10'b1000001001;
        rom[9]  = 10'b1010111010;
        rom[11] = 10'b0010000010;
        rom[40] = 10'b0010000010;

        // start, ready, redirect, rpc | valid, instr, ipc, count, halted, rom_addr
        tbl.push_back(mk(1, 1, 0, 0,  0, 10'd0, 0, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(0), 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(1), 1, 1, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(2), 2, 2, 0, 3));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(3), 3, 3, 0, 4));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(4), 4, 4, 0, 5));
        for (int k = 0; k < 3; k++)
            tbl.push_back(mk(0, 0, 0, 0,  1, w(4), 4, 4, 0, 5));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(5), 5, 5, 0, 6));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(6), 6, 6, 0, 7));
        tbl.push_back(mk(0, 1, 0, 0,  0, w(6), 6, 7, 0, 9));
        tbl.push_back(mk(0, 1, 0, 0,  1, 10'b1010111010, 9, 7, 0, 10));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(10), 10, 8, 0, 11));
        tbl.push_back(mk(0, 1, 1, 28, 0, w(10), 10, 9, 0, 28));
        for (int j = 0; j < 12; j++)
            tbl.push_back(mk(0, 1, 0, 0, 1, w(28 + j), 10'(28 + j), 16'(9 + j), 0, 10'(29 + j)));
        tbl.push_back(mk(0, 1, 0, 0,  0, w(39), 39, 21, 1, 40));
        tbl.push_back(mk(0, 1, 1, 5,  0, w(39), 39, 21, 1, 40));
        tbl.push_back(mk(1, 1, 0, 0,  0, w(39), 39, 0, 0, 0));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(0), 0, 0, 0, 1));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(1), 1, 1, 0, 2));
        tbl.push_back(mk(0, 1, 0, 0,  1, w(2), 2, 2, 0, 3));

        rst_n = 1'b0;
        start = 1'b0;
        instr_ready = 1'b0;
        redirect = 1'b0;
        redirect_pc = '0;
        step();
        step();
        chk_reset_values("reset");
        rst_n = 1'b1;
        step();

        foreach (tbl[i]) begin
            start       = tbl[i].start;
            instr_ready = tbl[i].ready;
            redirect    = tbl[i].redirect;
            redirect_pc = tbl[i].rpc;
            step();
            chk($sformatf("row%0d instr_valid", i), 32'(instr_valid), 32'(tbl[i].e_valid));
            chk($sformatf("row%0d instr", i),       32'(instr),       32'(tbl[i].e_instr));
            chk($sformatf("row%0d instr_pc", i),    32'(instr_pc),    32'(tbl[i].e_ipc));
            chk($sformatf("row%0d instr_count", i), 32'(instr_count), 32'(tbl[i].e_count));
            chk($sformatf("row%0d halted", i),      32'(halted),      32'(tbl[i].e_halted));
            chk($sformatf("row%0d rom_addr", i),    32'(rom_addr),    32'(tbl[i].e_addr));
        end
        start = 1'b0;
        redirect = 1'b0;

        // Asynchronous reset mid-stream takes effect before the next edge.
        #2;
        rst_n = 1'b0;
        #1;
        chk_reset_values("async_reset");
        rom[7]  = w(7);
        rom[9]  = w(9);
        rom[11] = w(11);
        rom[40] = w(40);
        step();
        #2;
        rst_n = 1'b1;

        // Redirect to the last address wraps pc to 0.
        start = 1'b1;
        step();
        chk("wrap start valid", 32'(instr_valid), 32'd0);
        start = 1'b0;
        step();
        chk("wrap first ipc", 32'(instr_pc), 32'd0);
        redirect = 1'b1;
        redirect_pc = 10'd1023;
        step();
        chk("wrap flush valid", 32'(instr_valid), 32'd0);
        chk("wrap flush addr", 32'(rom_addr), 32'd1023);
        chk("wrap flush count", 32'(instr_count), 32'd1);
        redirect = 1'b0;
        step();
        chk("wrap ipc 1023", 32'(instr_pc), 32'd1023);
        chk("wrap instr 1023", 32'(instr), 32'(w(1023)));
        chk("wrap addr 0", 32'(rom_addr), 32'd0);
        step();
        chk("wrap ipc 0", 32'(instr_pc), 32'd0);
        chk("wrap count 2", 32'(instr_count), 32'd2);

        // Continuous streaming into counter saturation; start in RUN is ignored.
        for (int m = 1; m <= 65540; m++) begin
            start = (m == 1);
            step();
            if (m == 1) begin
                chk("start in run ipc", 32'(instr_pc), 32'd1);
                chk("start in run count", 32'(instr_count), 32'd3);
                chk("start in run addr", 32'(rom_addr), 32'd2);
            end
            if (m == 65532) chk("count 65534", 32'(instr_count), 32'd65534);
            if (m == 65533) chk("count 65535", 32'(instr_count), 32'd65535);
        end
        start = 1'b0;
        chk("count saturated", 32'(instr_count), 32'hFFFF);
        chk("stream ipc", 32'(instr_pc), 32'd4);
        chk("stream valid", 32'(instr_valid), 32'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
